iodec_select_gen: RTL and testbench

- Parametrised, registered successor to the fixed 4-input I/O decode gates in the IODEC netlist.
- Decodes CPU I/O addresses against per-channel base/mask pairs and drives one-hot, active-low chip-select strobes.
- Each channel selects level mode (strobe follows the access) or pulse mode (strobe lasts a programmed number of cycles).
- Sits between the CPU I/O bus and peripheral select lines inside the Slipstream I/O block.

---
 rtl/iodec_select_gen.sv | 86 ++++++++
 tb/tb_iodec_select_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/iodec_select_gen.sv
// iodec_select_gen: masked I/O address decode to one-hot active-low selects, level or fixed-length pulse per channel
module iodec_select_gen #(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = 8,
   parameter int PULSE_W  = 3
) (
   input  logic                         MasterClock,
   input  logic                         Reset,
   input  logic [ADDR_W-1:0]            Addr,
   input  logic                         IoStrobe,
   input  logic [CHANNELS*ADDR_W-1:0]   ChBase,
   input  logic [CHANNELS*ADDR_W-1:0]   ChMask,
   input  logic [CHANNELS*PULSE_W-1:0]  ChPulseLen,
   input  logic [CHANNELS-1:0]          ChMode,
   output logic [CHANNELS-1:0]          SelL,
   output logic                         Hit,
   output logic                         MultiHit,
   output logic                         Busy
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   typedef enum logic [1:0] {IDLE, LEVEL, PULSE, WAIT_REL} state_t;
   state_t state_q, state_d;
   logic [PULSE_W-1:0] cnt_q, cnt_d, len;
   logic [CW-1:0] ch_q, ch_d, win;
   logic [CHANNELS-1:0] match, sel_q, sel_d;
   logic hit_q, multi_q, any;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_match
      assign match[i] = IoStrobe & (((Addr ^ ChBase[i*ADDR_W +: ADDR_W]) & ChMask[i*ADDR_W +: ADDR_W]) == '0);
   end

   always_comb begin
      win = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) win = match[i] ? CW'(i) : win;
   end

   assign any = |match;
   assign len = ChPulseLen[win*PULSE_W +: PULSE_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      sel_d   = '1;
      case (state_q)
         IDLE: if (any) begin
            ch_d    = win;
            sel_d   = ~(CHANNELS'(1) << win);
            cnt_d   = (len == '0) ? '0 : len - PULSE_W'(1);
            state_d = ChMode[win] ? PULSE : LEVEL;
         end
         // Any loss of ownership drops to IDLE, giving a one-cycle all-high gap.
         LEVEL: if (match[ch_q] && win == ch_q) sel_d = sel_q;
                else state_d = IDLE;
         PULSE: if (cnt_q != '0) begin
            cnt_d = cnt_q - PULSE_W'(1);
            sel_d = sel_q;
         end else state_d = IoStrobe ? WAIT_REL : IDLE;
         WAIT_REL: state_d = IoStrobe ? WAIT_REL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MasterClock) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch_q    <= '0;
         sel_q   <= '1;
         hit_q   <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         sel_q   <= sel_d;
         hit_q   <= any;
         multi_q <= |(match & (match - CHANNELS'(1)));
      end
   end

   assign SelL     = sel_q;
   assign Hit      = hit_q;
   assign MultiHit = multi_q;
   assign Busy     = state_q != IDLE;
endmodule

// File: tb/tb_iodec_select_gen.sv
// tb_iodec_select_gen: scenario tasks with a per-cycle expected-output queue {SelL,Hit,MultiHit,Busy}
module tb_iodec_select_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  addr = '0;
   logic        io = 1'b0;
   logic [31:0] base = '0, mask = '0;
   logic [11:0] plen = '0;
   logic [3:0]  mode = '0;
   logic [3:0]  sel_l;
   logic        hit, multi, busy;
   logic [6:0]  exp_q [$];
   logic [6:0]  obs, want;
   int          vectors = 0, errors = 0;

   iodec_select_gen #(.CHANNELS(4), .ADDR_W(8), .PULSE_W(3)) dut (
      .MasterClock(clk), .Reset(rst), .Addr(addr), .IoStrobe(io),
      .ChBase(base), .ChMask(mask), .ChPulseLen(plen), .ChMode(mode),
      .SelL(sel_l), .Hit(hit), .MultiHit(multi), .Busy(busy)
   );

   always #5 clk = ~clk;

   task automatic set_ch(input int i, input logic [7:0] b, input logic [7:0] m, input logic [2:0] l, input logic md);
      base[i*8 +: 8] = b;
      mask[i*8 +: 8] = m;
      plen[i*3 +: 3] = l;
      mode[i]        = md;
   endtask

   task automatic park_all();
      for (int i = 0; i < 4; i++) set_ch(i, 8'h80, 8'hFF, 3'd0, 1'b0);
   endtask

   // stimulus rows are {Reset, IoStrobe, Addr}; expected rows are outputs after the following edge
   task automatic test_reset();
      logic [9:0] stim [3];
      logic [6:0] exp [3];
      park_all();
      stim = '{10'h200, 10'h200, 10'h000};
      exp  = '{7'b1111_000, 7'b1111_000, 7'b1111_000};
      for (int k = 0; k < 3; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL reset step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   task automatic test_level();
      logic [9:0] stim [7];
      logic [6:0] exp [7];
      park_all();
      set_ch(0, 8'h10, 8'hF0, 3'd0, 1'b0);
      stim = '{10'h113, 10'h113, 10'h113, 10'h113, 10'h113, 10'h013, 10'h013};
      exp  = '{7'b1110_101, 7'b1110_101, 7'b1110_101, 7'b1110_101, 7'b1110_101, 7'b1111_000, 7'b1111_000};
      for (int k = 0; k < 7; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL level step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   task automatic test_pulse_hold();
      logic [9:0] stim [16];
      logic [6:0] exp [16];
      park_all();
      set_ch(0, 8'h10, 8'hF0, 3'd0, 1'b0);
      set_ch(2, 8'h40, 8'hFF, 3'd3, 1'b1);
      for (int k = 0; k < 10; k++) begin
         stim[k] = 10'h140;
         exp[k]  = (k < 3) ? 7'b1011_101 : 7'b1111_101;
      end
      stim[10] = 10'h040; exp[10] = 7'b1111_000;
      stim[11] = 10'h140; exp[11] = 7'b1011_101;
      stim[12] = 10'h140; exp[12] = 7'b1011_101;
      stim[13] = 10'h140; exp[13] = 7'b1011_101;
      stim[14] = 10'h040; exp[14] = 7'b1111_000;
      stim[15] = 10'h040; exp[15] = 7'b1111_000;
      for (int k = 0; k < 16; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL pulse_hold step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   task automatic test_pulse_len0();
      logic [9:0] stim [4];
      logic [6:0] exp [4];
      park_all();
      set_ch(0, 8'h10, 8'hF0, 3'd0, 1'b0);
      set_ch(1, 8'h30, 8'hFF, 3'd0, 1'b1);
      stim = '{10'h130, 10'h130, 10'h030, 10'h030};
      exp  = '{7'b1101_101, 7'b1111_101, 7'b1111_000, 7'b1111_000};
      for (int k = 0; k < 4; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL pulse_len0 step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   task automatic test_multihit();
      logic [9:0] stim [3];
      logic [6:0] exp [3];
      park_all();
      set_ch(0, 8'h20, 8'hF0, 3'd0, 1'b0);
      set_ch(1, 8'h20, 8'hFF, 3'd3, 1'b1);
      stim = '{10'h120, 10'h020, 10'h020};
      exp  = '{7'b1110_111, 7'b1111_000, 7'b1111_000};
      for (int k = 0; k < 3; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL multihit step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   task automatic test_switch();
      logic [9:0] stim [6];
      logic [6:0] exp [6];
      park_all();
      set_ch(0, 8'h10, 8'hF0, 3'd0, 1'b0);
      set_ch(3, 8'hC0, 8'hF0, 3'd0, 1'b0);
      stim = '{10'h111, 10'h111, 10'h1C5, 10'h1C5, 10'h0C5, 10'h0C5};
      exp  = '{7'b1110_101, 7'b1110_101, 7'b1111_100, 7'b0111_101, 7'b1111_000, 7'b1111_000};
      for (int k = 0; k < 6; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL switch step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [9:0] stim [6];
      logic [6:0] exp [6];
      park_all();
      set_ch(2, 8'h40, 8'hFF, 3'd5, 1'b1);
      stim = '{10'h140, 10'h340, 10'h040, 10'h040, 10'h040, 10'h040};
      exp  = '{7'b1011_101, 7'b1111_000, 7'b1111_000, 7'b1111_000, 7'b1111_000, 7'b1111_000};
      for (int k = 0; k < 6; k++) begin
         {rst, io, addr} = stim[k];
         exp_q.push_back(exp[k]);
         @(posedge clk); #1;
         obs = {sel_l, hit, multi, busy}; want = exp_q.pop_front(); vectors++;
         if (obs !== want) begin errors++; $display("FAIL reset_mid_pulse step %0d: got %b want %b", k, obs, want); end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_level();
      test_pulse_hold();
      test_pulse_len0();
      test_multihit();
      test_switch();
      test_reset_mid_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
